alu_div_sequencer: RTL and testbench
====================================

Name: alu_div_sequencer

Overview:
- Multicycle signed restoring divider controller for the ALU divide path (opcode 7).
- Replaces the single-cycle combinational divide with a 1-bit-per-cycle iteration engine behind a valid/ready handshake.
- Returns quotient and remainder together, plus divide-by-zero and overflow flags.
- Sits between the control unit and the ALU result mux; the control unit holds the instruction until out_valid.

Parameters:
- WIDTH, 32, operand, quotient and remainder width; also the iteration count.

Ports:
- clock  in  1  system clock, rising edge
- clear_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous abort; returns to IDLE and discards any op in flight
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept an op
- dividend  in  WIDTH  two's-complement dividend (ALU a)
- divisor  in  WIDTH  two's-complement divisor (ALU b)
- out_valid  out  1  results valid
- out_ready  in  1  consumer takes results
- quotient  out  WIDTH  signed quotient
- remainder  out  WIDTH  signed remainder
- div_by_zero  out  1  divisor was 0
- overflow  out  1  most-negative / -1 case

Behaviour:
- States: IDLE, CALC, FIX, DONE. Iteration counter is 6 bits.
- Reset (clear_n low, asynchronous):
  - state = IDLE; quotient, remainder, flags, out_valid = 0.
  - in_ready = 0 while clear_n is low; in_ready = (state == IDLE) otherwise.
- Accept occurs on the edge where in_valid && in_ready.
  - Latch |dividend| and |divisor|, sign_a = dividend MSB, sign_q = dividend MSB ^ divisor MSB.
  - Partial remainder = 0, counter = WIDTH, next state = CALC.
- Divisor == 0 at accept: go directly to DONE.
  - quotient = all ones, remainder = dividend (unmodified), div_by_zero = 1, overflow = 0.
  - out_valid is high 1 cycle after accept.
- CALC, each edge:
  - Shift {rem, quo} left by 1.
  - trial = rem_shifted - |divisor| (WIDTH+1 bits).
  - If trial >= 0: rem = trial and quo LSB = 1; else quo LSB = 0.
  - Decrement counter; when it goes from 1 to 0, next state = FIX.
- FIX, one edge:
  - quotient = sign_q ? -quo : quo.
  - remainder = sign_a ? -rem : rem.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - overflow = 1 iff dividend == 2^(WIDTH-1) negative and divisor == -1. In that case quotient = 0x80000000 (wrapped) and remainder = 0.
  - Next state = DONE.
- Latency: out_valid rises 33 edges after the accept edge (WIDTH + 1).
- DONE:
  - out_valid = 1; quotient, remainder and flags held stable until the out_ready edge.
  - On out_valid && out_ready: next state = IDLE, out_valid = 0 on that edge.
  - Outputs keep their last values until the next accept; flags clear on the next accept.
- No same-cycle back-to-back: in_ready is 0 in CALC, FIX and DONE. Minimum issue interval is 35 cycles (33 for the op, 1 in DONE, 1 in IDLE).
- flush takes priority over every transition.
  - Next state = IDLE and out_valid = 0; output data registers are untouched.
  - flush in IDLE with in_valid high: no accept occurs.
- Operand inputs are ignored after the accept edge; changing them mid-op has no effect.
- clear_n asserted mid-op: immediate return to the reset values; no partial result is ever presented.

Test Plan:
- 100 / 7, out_ready held high -> out_valid exactly 33 cycles after accept; quotient = 14, remainder = 2, both flags 0.
- -100 / 7 and 100 / -7 -> quotients 0xFFFFFFF2 and 0xFFFFFFF2; remainders 0xFFFFFFFE and 0x00000002 respectively.
- 0x12345678 / 0 -> out_valid 1 cycle after accept; quotient 0xFFFFFFFF, remainder 0x12345678, div_by_zero = 1.
- 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, overflow = 1.
- Accept 1000 / 3, pulse flush at cycle 10 -> out_valid never rises and in_ready = 1 the next cycle; then 9 / 2 -> quotient 4, remainder 1.
- 50 / 5 with out_ready low for 5 cycles after out_valid -> quotient 10 and remainder 0 held stable, in_ready stays 0; out_valid drops on the edge after out_ready rises.
- clear_n pulsed low at cycle 20 of an op -> all outputs 0 immediately, in_ready = 1 after release, no result presented.

Source files
------------

// File: rtl/alu_div_sequencer.sv
// -----------------------------------------------------------------------------
// alu_div_sequencer
//
// Multicycle signed restoring divider for the ALU divide path. Operands are
// taken through a valid/ready handshake, converted to magnitudes, divided one
// quotient bit per clock, then sign-corrected. Quotient, remainder and the
// divide-by-zero / overflow flags are presented together behind out_valid and
// held until the consumer takes them with out_ready.
//
// Ports:
//   clock       - system clock, rising edge
//   clear_n     - asynchronous active-low reset
//   flush       - synchronous abort, returns to IDLE and drops any op in flight
//   in_valid    - operands valid
//   in_ready    - block can accept an op (IDLE and out of reset)
//   dividend    - two's-complement dividend
//   divisor     - two's-complement divisor
//   out_valid   - results valid
//   out_ready   - consumer takes results
//   quotient    - signed quotient, truncated toward zero
//   remainder   - signed remainder, sign follows the dividend
//   div_by_zero - divisor was zero
//   overflow    - most-negative dividend divided by -1
// -----------------------------------------------------------------------------
module alu_div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES     = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [5:0]       ITER     = 6'(WIDTH);

    // Two's-complement negation.
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return (~v) + ONE;
    endfunction

    // Magnitude of a two's-complement value; the most-negative value maps to
    // 2^(WIDTH-1), which is still correct when read as unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] m;
        if (v[WIDTH-1]) begin
            m = negate(v);
        end else begin
            m = v;
        end
        return m;
    endfunction

    state_t           state_q,       state_d;
    logic [WIDTH-1:0] rem_q,         rem_d;
    logic [WIDTH-1:0] quo_q,         quo_d;
    logic [WIDTH-1:0] dvs_q,         dvs_d;
    logic [5:0]       cnt_q,         cnt_d;
    logic             sign_a_q,      sign_a_d;
    logic             sign_quo_q,    sign_quo_d;
    logic             ovf_pend_q,    ovf_pend_d;
    logic [WIDTH-1:0] quotient_q,    quotient_d;
    logic [WIDTH-1:0] remainder_q,   remainder_d;
    logic             dbz_q,         dbz_d;
    logic             ovf_q,         ovf_d;
    logic             out_valid_q,   out_valid_d;

    logic             in_ready_s;
    logic             accept_s;
    logic             dvs_zero_s;
    logic [WIDTH:0]   rem_sh_s;
    logic [WIDTH:0]   trial_s;

    // State register.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_d = dvs_zero_s ? ST_DONE : ST_CALC;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (cnt_q == 6'd1) begin
                        state_d = ST_FIX;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
                ST_FIX: begin
                    state_d = ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // FSM outputs: ready only in IDLE and never while reset is held.
    always_comb begin
        in_ready_s = clear_n & (state_q == ST_IDLE);
        accept_s   = in_valid & in_ready_s & ~flush;
        dvs_zero_s = (divisor == ZERO);
    end

    // Datapath next values: operand capture, restoring step, sign fix-up.
    always_comb begin
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        sign_a_d    = sign_a_q;
        sign_quo_d  = sign_quo_q;
        ovf_pend_d  = ovf_pend_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        // {rem, quo} shifted left by one; the top bit keeps the trial honest.
        rem_sh_s = {rem_q, quo_q[WIDTH-1]};
        trial_s  = rem_sh_s - {1'b0, dvs_q};

        if (flush) begin
            // Abort: drop the handshake, leave presented data as it was.
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        sign_a_d   = dividend[WIDTH-1];
                        sign_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        dvs_d      = magnitude(divisor);
                        quo_d      = magnitude(dividend);
                        rem_d      = ZERO;
                        cnt_d      = ITER;
                        ovf_pend_d = (dividend == MOST_NEG) && (divisor == ONES);
                        dbz_d      = 1'b0;
                        ovf_d      = 1'b0;
                        if (dvs_zero_s) begin
                            quotient_d  = ONES;
                            remainder_d = dividend;
                            dbz_d       = 1'b1;
                            out_valid_d = 1'b1;
                        end else begin
                            out_valid_d = 1'b0;
                        end
                    end else begin
                        out_valid_d = 1'b0;
                    end
                end
                ST_CALC: begin
                    // Negative trial (top bit set) means the divisor did not fit.
                    quo_d = {quo_q[WIDTH-2:0], ~trial_s[WIDTH]};
                    if (trial_s[WIDTH]) begin
                        rem_d = rem_sh_s[WIDTH-1:0];
                    end else begin
                        rem_d = trial_s[WIDTH-1:0];
                    end
                    cnt_d = cnt_q - 6'd1;
                end
                ST_FIX: begin
                    // MOST_NEG / -1 falls out naturally as the wrapped 2^(WIDTH-1).
                    quotient_d  = sign_quo_q ? negate(quo_q) : quo_q;
                    remainder_d = sign_a_q   ? negate(rem_q) : rem_q;
                    ovf_d       = ovf_pend_q;
                    out_valid_d = 1'b1;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                    end else begin
                        out_valid_d = 1'b1;
                    end
                end
                default: begin
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            rem_q       <= ZERO;
            quo_q       <= ZERO;
            dvs_q       <= ZERO;
            cnt_q       <= 6'd0;
            sign_a_q    <= 1'b0;
            sign_quo_q  <= 1'b0;
            ovf_pend_q  <= 1'b0;
            quotient_q  <= ZERO;
            remainder_q <= ZERO;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            sign_a_q    <= sign_a_d;
            sign_quo_q  <= sign_quo_d;
            ovf_pend_q  <= ovf_pend_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_alu_div_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_div_sequencer
//
// Directed bench for alu_div_sequencer. A behavioural model (plain signed
// arithmetic plus the zero-divisor and overflow special cases) supplies the
// expected result of each accepted op; a compare process checks the outputs
// against it on every cycle out_valid is high. Each directed vector also
// carries hand-computed literal results, latency and handshake checks.
// -----------------------------------------------------------------------------
module tb_alu_div_sequencer;

    logic        clock = 1'b0;
    logic        clear_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;
    logic        overflow;

    int n_vec = 0;
    int n_err = 0;

    // Model expectation for the op currently in flight.
    logic        exp_pending = 1'b0;
    logic [31:0] m_q = 32'd0;
    logic [31:0] m_r = 32'd0;
    logic        m_dbz = 1'b0;
    logic        m_ovf = 1'b0;

    alu_div_sequencer #(.WIDTH(32)) dut (
        .clock       (clock),
        .clear_n     (clear_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Signed division semantics: truncate toward zero, remainder follows dividend.
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic dbz, output logic ovf);
        int sa;
        int sb;
        sa  = a;
        sb  = b;
        dbz = 1'b0;
        ovf = 1'b0;
        if (b == 32'd0) begin
            q   = 32'hFFFF_FFFF;
            r   = a;
            dbz = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q   = 32'h8000_0000;
            r   = 32'd0;
            ovf = 1'b1;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
    endtask

    // Compare process: any presented result must match the model.
    always @(negedge clock) begin
        if (clear_n && out_valid) begin
            if (!exp_pending) begin
                check("spurious_out_valid", {31'd0, out_valid}, 32'd0);
            end else begin
                check("model_quotient",  quotient,  m_q);
                check("model_remainder", remainder, m_r);
                check("model_dbz",       {31'd0, div_by_zero}, {31'd0, m_dbz});
                check("model_ovf",       {31'd0, overflow},    {31'd0, m_ovf});
            end
        end
    end

    task automatic wait_ready();
        int k;
        k = 0;
        while (!in_ready && k < 100) begin
            @(posedge clock);
            #1;
            k++;
        end
        check("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
    endtask

    // One full op with literal expectations; hold = cycles out_ready stays low.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] lq, input logic [31:0] lr,
                          input logic ldbz, input logic lovf, input int hold);
        int k;
        bit seen;
        wait_ready();
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        dividend  = a;
        divisor   = b;
        @(posedge clock);
        model(a, b, m_q, m_r, m_dbz, m_ovf);
        exp_pending = 1'b1;
        #1;
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 60) begin
            @(negedge clock);
            if (out_valid) begin
                seen = 1'b1;
            end else begin
                @(posedge clock);
                k++;
            end
        end
        check("latency_edges", 32'(k), ldbz ? 32'd0 : 32'd33);
        check("lit_quotient",  quotient,  lq);
        check("lit_remainder", remainder, lr);
        check("lit_dbz", {31'd0, div_by_zero}, {31'd0, ldbz});
        check("lit_ovf", {31'd0, overflow},    {31'd0, lovf});
        for (int i = 0; i < hold; i++) begin
            @(posedge clock);
            @(negedge clock);
            check("hold_out_valid", {31'd0, out_valid}, 32'd1);
            check("hold_in_ready",  {31'd0, in_ready},  32'd0);
        end
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        exp_pending = 1'b0;
        @(negedge clock);
        check("post_out_valid", {31'd0, out_valid}, 32'd0);
        check("post_in_ready",  {31'd0, in_ready},  32'd1);
    endtask

    initial begin
        clear_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = 32'd0;
        divisor   = 32'd0;
        #2;
        check("rst_in_ready",  {31'd0, in_ready},  32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_quotient",  quotient,  32'd0);
        check("rst_remainder", remainder, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        check("rst_ovf", {31'd0, overflow},    32'd0);
        @(negedge clock);
        clear_n = 1'b1;
        #1;
        check("rel_in_ready", {31'd0, in_ready}, 32'd1);

        run_op(32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 1'b0, 0);
        run_op(-32'sd100,     32'd7,         32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0, 0);
        run_op(32'd100,       -32'sd7,       32'hFFFF_FFF2, 32'h0000_0002, 1'b0, 1'b0, 0);
        run_op(32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b0, 0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0, 1'b1, 0);
        run_op(-32'sd7,       -32'sd2,       32'd3,         32'hFFFF_FFFF, 1'b0, 1'b0, 0);
        run_op(32'h8000_0000, 32'd2,         32'hC000_0000, 32'd0,         1'b0, 1'b0, 0);
        run_op(32'd5,         32'h8000_0000, 32'd0,         32'd5,         1'b0, 1'b0, 0);
        run_op(32'h7FFF_FFFF, 32'd1,         32'h7FFF_FFFF, 32'd0,         1'b0, 1'b0, 0);
        run_op(32'd0,         32'd5,         32'd0,         32'd0,         1'b0, 1'b0, 0);
        run_op(32'd50,        32'd5,         32'd10,        32'd0,         1'b0, 1'b0, 5);

        // Flush mid-op: no result, ready again, presented data untouched.
        wait_ready();
        in_valid = 1'b1;
        dividend = 32'd1000;
        divisor  = 32'd3;
        @(posedge clock);
        exp_pending = 1'b0;
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        check("flush_in_ready",  {31'd0, in_ready},  32'd1);
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_keeps_quotient",  quotient,  m_q);
        check("flush_keeps_remainder", remainder, m_r);
        // Flush in IDLE wins over a valid request.
        in_valid = 1'b1;
        dividend = 32'd9;
        divisor  = 32'd2;
        flush    = 1'b1;
        @(posedge clock);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_idle_no_accept", {31'd0, in_ready}, 32'd1);
        repeat (40) @(negedge clock);
        check("flush_no_result", {31'd0, out_valid}, 32'd0);
        run_op(32'd9, 32'd2, 32'd4, 32'd1, 1'b0, 1'b0, 0);

        // Reset mid-op: outputs clear immediately and nothing is presented.
        wait_ready();
        in_valid = 1'b1;
        dividend = 32'd1000;
        divisor  = 32'd3;
        @(posedge clock);
        exp_pending = 1'b0;
        #1;
        in_valid = 1'b0;
        repeat (19) @(posedge clock);
        #1;
        clear_n = 1'b0;
        #1;
        check("mid_rst_in_ready",  {31'd0, in_ready},  32'd0);
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_quotient",  quotient,  32'd0);
        check("mid_rst_remainder", remainder, 32'd0);
        check("mid_rst_dbz", {31'd0, div_by_zero}, 32'd0);
        check("mid_rst_ovf", {31'd0, overflow},    32'd0);
        @(negedge clock);
        clear_n = 1'b1;
        #1;
        check("mid_rel_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (40) @(negedge clock);
        check("mid_rst_no_result", {31'd0, out_valid}, 32'd0);
        run_op(32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
